// File: rtl/alu_slice_sequencer_if.sv
// alu_slice_sequencer_if: request/response handshake plus the slice bus between the sequencer and its ALU slice.
interface alu_slice_sequencer_if #(
    parameter int W = 16,
    parameter int S = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_flag;
    logic [1:0]   rsp_cmp;
    logic [S-1:0] sl_a;
    logic [S-1:0] sl_b;
    logic [2:0]   sl_op;
    logic         sl_p_c;
    logic [S-1:0] sl_out;
    logic         sl_n_c;
    logic [1:0]   sl_cmp;

    modport master (
        input  req_valid, req_op, req_a, req_b, rsp_ready, sl_out, sl_n_c, sl_cmp,
        output req_ready, rsp_valid, rsp_result, rsp_flag, rsp_cmp, sl_a, sl_b, sl_op, sl_p_c
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, rsp_ready, sl_out, sl_n_c, sl_cmp,
        input  req_ready, rsp_valid, rsp_result, rsp_flag, rsp_cmp, sl_a, sl_b, sl_op, sl_p_c
    );
endinterface

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs one W-bit op through an external S-bit ALU slice over W/S cycles,
// chaining carry/shift bits between passes and assembling the full-width result.
module alu_slice_sequencer #(
    parameter int W = 16,
    parameter int S = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_slice_sequencer_if.master   bus
);
    localparam int N  = W / S;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_RSH = 3'b001;
    localparam logic [2:0] OP_POP = 3'b010;
    localparam logic [2:0] OP_CMP = 3'b011;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          chain_q, chain_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          flag_q, flag_d;
    logic [1:0]    cmp_q, cmp_d;

    logic run, chained, up, last, cmp_hit;

    assign run     = state_q == ST_RUN;
    assign chained = op_q == OP_ADD || op_q == OP_RSH;
    assign up      = op_q == OP_ADD || op_q == OP_POP;
    assign last    = up ? (idx_q == IW'(N - 1)) : (idx_q == '0);
    assign cmp_hit = op_q == OP_CMP && bus.sl_cmp != 2'b00;

    assign bus.req_ready  = state_q == ST_IDLE;
    assign bus.rsp_valid  = state_q == ST_DONE;
    assign bus.rsp_result = acc_q;
    assign bus.rsp_flag   = flag_q;
    assign bus.rsp_cmp    = cmp_q;
    assign bus.sl_a       = run ? a_q[idx_q*S +: S] : '0;
    assign bus.sl_b       = run ? b_q[idx_q*S +: S] : '0;
    assign bus.sl_p_c     = run && chained ? chain_q : 1'b0;
    assign bus.sl_op      = op_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        chain_d = chain_q;
        idx_d   = idx_q;
        flag_d  = flag_q;
        cmp_d   = cmp_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                op_d    = bus.req_op;
                a_d     = bus.req_a;
                b_d     = bus.req_b;
                acc_d   = '0;
                chain_d = 1'b0;
                flag_d  = 1'b0;
                cmp_d   = 2'b00;
                idx_d   = (bus.req_op == OP_RSH || bus.req_op == OP_CMP) ? IW'(N - 1) : '0;
                // ops 1xx are unsupported and complete immediately with an all-zero response
                state_d = bus.req_op[2] ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (chained) begin
                    acc_d[idx_q*S +: S] = bus.sl_out;
                    chain_d             = bus.sl_n_c;
                end
                if (op_q == OP_POP) acc_d = acc_q + W'(bus.sl_out);
                if (last && chained) flag_d = bus.sl_n_c;
                if (cmp_hit) cmp_d = bus.sl_cmp;
                idx_d   = up ? idx_q + 1'b1 : idx_q - 1'b1;
                state_d = (last || cmp_hit) ? ST_DONE : ST_RUN;
            end
            ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            chain_q <= 1'b0;
            idx_q   <= '0;
            flag_q  <= 1'b0;
            cmp_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            chain_q <= chain_d;
            idx_q   <= idx_d;
            flag_q  <= flag_d;
            cmp_q   <= cmp_d;
        end
    end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: scoreboard bench with a behavioural 4-bit ALU slice attached to the sequencer.
module tb_alu_slice_sequencer;
    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    typedef struct {
        logic [W-1:0] r;
        logic         f;
        logic [1:0]   c;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_slice_sequencer_if #(.W(W), .S(S)) bus();
    alu_slice_sequencer #(.W(W), .S(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // behavioural slice: add with carry, shift right through p_c, popcount, unsigned compare
    always_comb begin
        bus.sl_out = '0;
        bus.sl_n_c = 1'b0;
        bus.sl_cmp = 2'b00;
        case (bus.sl_op)
            3'd0: {bus.sl_n_c, bus.sl_out} = {1'b0, bus.sl_a} + {1'b0, bus.sl_b} + (S + 1)'(bus.sl_p_c);
            3'd1: begin
                bus.sl_out = {bus.sl_p_c, bus.sl_a[S-1:1]};
                bus.sl_n_c = bus.sl_a[0];
            end
            3'd2: bus.sl_out = S'($countones(bus.sl_a));
            3'd3: bus.sl_cmp = bus.sl_a > bus.sl_b ? 2'b01 : bus.sl_a < bus.sl_b ? 2'b10 : 2'b00;
            default: ;
        endcase
    end

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        logic found;
        e.r = '0; e.f = 1'b0; e.c = 2'b00; e.lat = N + 1; found = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; e.r = s[W-1:0]; e.f = s[W]; end
            3'd1: begin e.r = a >> 1; e.f = a[0]; end
            3'd2: e.r = W'($countones(a));
            3'd3: begin
                e.c = a > b ? 2'b01 : a < b ? 2'b10 : 2'b00;
                for (int p = 0; p < N; p++)
                    if (!found && a[W-1-p*S -: S] != b[W-1-p*S -: S]) begin
                        e.lat = p + 2;
                        found = 1'b1;
                    end
            end
            default: e.lat = 1;
        endcase
        return e;
    endfunction

    function automatic logic exp_pc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int idx);
        int m;
        if (op == 3'd0) begin
            m = (1 << (idx * S)) - 1;
            return 1'(((int'(a) & m) + (int'(b) & m)) >> (idx * S));
        end
        if (op == 3'd1) return idx == N - 1 ? 1'b0 : a[(idx + 1) * S];
        return 1'b0;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input string name);
        exp_t g;
        int lat, idx;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.rsp_ready = 1'b0;
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL %s req_ready got %b want 1", name, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_op = 3'($urandom); bus.req_a = W'($urandom); bus.req_b = W'($urandom);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 4 * N) begin
            idx = (op == 3'd0 || op == 3'd2) ? lat - 1 : N - lat;
            if (lat <= N) begin
                tests++;
                if (bus.sl_a !== a[idx*S +: S] || bus.sl_b !== b[idx*S +: S] || bus.sl_p_c !== exp_pc(op, a, b, idx)) begin
                    fails++;
                    $display("FAIL %s slice step %0d got a=%h b=%h p_c=%b want a=%h b=%h p_c=%b", name, lat - 1,
                             bus.sl_a, bus.sl_b, bus.sl_p_c, a[idx*S +: S], b[idx*S +: S], exp_pc(op, a, b, idx));
                end
            end
            @(negedge clk);
            lat++;
        end
        g = sb.pop_front();
        tests++;
        if (lat != g.lat) begin
            fails++; $display("FAIL %s latency got %0d want %0d", name, lat, g.lat);
        end
        tests++;
        if (bus.rsp_result !== g.r || bus.rsp_flag !== g.f || bus.rsp_cmp !== g.c || bus.sl_op !== op) begin
            fails++;
            $display("FAIL %s response got r=%h f=%b c=%b op=%b want r=%h f=%b c=%b op=%b", name,
                     bus.rsp_result, bus.rsp_flag, bus.rsp_cmp, bus.sl_op, g.r, g.f, g.c, op);
        end
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = (i == 0);
            @(negedge clk);
            bus.req_valid = 1'b0;
            tests++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_result !== g.r ||
                bus.rsp_flag !== g.f || bus.rsp_cmp !== g.c || bus.sl_op !== op) begin
                fails++;
                $display("FAIL %s hold %0d got v=%b rdy=%b r=%h f=%b c=%b op=%b want v=1 rdy=0 r=%h f=%b c=%b op=%b",
                         name, i, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flag, bus.rsp_cmp,
                         bus.sl_op, g.r, g.f, g.c, op);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        tests++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL %s post-handshake got v=%b rdy=%b want v=0 rdy=1", name, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== '0 || bus.rsp_flag !== 1'b0 ||
            bus.rsp_cmp !== 2'b00 || bus.sl_a !== '0 || bus.sl_b !== '0 || bus.sl_p_c !== 1'b0 || bus.sl_op !== 3'b000) begin
            fails++;
            $display("FAIL %s got rdy=%b v=%b r=%h f=%b c=%b sa=%h sb=%h pc=%b op=%b want rdy=1 and rest 0", name,
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_flag, bus.rsp_cmp,
                     bus.sl_a, bus.sl_b, bus.sl_p_c, bus.sl_op);
        end
    endtask

    task automatic test_reset();
        #1 check_reset_outputs("reset_asserted");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_add();
        run_op(3'd0, 16'h00FF, 16'h0001, 0, "add_00ff");
        run_op(3'd0, 16'hFFFF, 16'h0001, 0, "add_ffff");
        run_op(3'd0, 16'h7A5C, 16'h19E7, 0, "add_mixed");
    endtask

    task automatic test_rshift();
        run_op(3'd1, 16'h8001, 16'h0000, 0, "rsh_8001");
        run_op(3'd1, 16'h0002, 16'h0000, 0, "rsh_0002");
        run_op(3'd1, 16'h1111, 16'h0000, 0, "rsh_1111");
    endtask

    task automatic test_popcount();
        run_op(3'd2, 16'hF0F1, 16'h0000, 0, "pop_f0f1");
        run_op(3'd2, 16'hFFFF, 16'h1234, 0, "pop_ffff");
        run_op(3'd2, 16'h0000, 16'hFFFF, 0, "pop_zero");
    endtask

    task automatic test_compare();
        run_op(3'd3, 16'h2000, 16'h1FFF, 0, "cmp_gt_msb");
        run_op(3'd3, 16'h1234, 16'h1235, 0, "cmp_lt_lsb");
        run_op(3'd3, 16'hBEEF, 16'hBEEF, 0, "cmp_eq");
        run_op(3'd3, 16'h12F4, 16'h1234, 0, "cmp_gt_mid");
    endtask

    task automatic test_backpressure();
        run_op(3'd0, 16'h1234, 16'h0F0F, 3, "bp_add");
        run_op(3'b101, 16'hABCD, 16'h1111, 2, "unsup_101");
        run_op(3'b111, 16'hFFFF, 16'hFFFF, 0, "unsup_111");
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 16'h1234; bus.req_b = 16'h4321; bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        bus.rsp_ready = 1'b0;
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL reset_no_response got %0d valid cycles want 0", seen);
        end
        run_op(3'd0, 16'h0F0F, 16'h00F1, 0, "add_after_reset");
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int na;
        for (int i = 0; i < 12; i++)
            run_op(3'($urandom_range(0, 4)), W'($urandom), W'($urandom), 0, "rand");
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 16'h0101; bus.req_b = 16'h0202; bus.rsp_ready = 1'b1;
        na = 0;
        acc[0] = 0; acc[1] = 0;
        for (int cyc = 0; cyc < 20 && na < 2; cyc++) begin
            if (bus.req_ready === 1'b1) begin acc[na] = cyc; na++; end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        tests++;
        if (na != 2 || acc[1] - acc[0] != N + 2) begin
            fails++; $display("FAIL spacing got accepts=%0d gap=%0d want accepts=2 gap=%0d", na, acc[1] - acc[0], N + 2);
        end
        repeat (N + 3) @(negedge clk);
        bus.rsp_ready = 1'b0;
        run_op(3'd3, 16'h0001, 16'h0000, 0, "cmp_after_b2b");
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_rshift();
        test_popcount();
        test_compare();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end
endmodule
